// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Op-code constants, FSM state type and op decode for alu_sliced.
//          Macro ALU_SLT_EN enables the set-less-than operation (op 111).
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_or  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b110;
  localparam logic [2:0] c_op_slt = 3'b111;
  localparam logic [2:0] c_op_nor = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Folds unsupported codes onto ADD so the datapath only sees legal ops.
  function automatic logic [2:0] alu_decode(input logic [2:0] op);
    case (op)
      c_op_and, c_op_or, c_op_add, c_op_sub, c_op_nor: alu_decode = op;
`ifdef ALU_SLT_EN
      c_op_slt: alu_decode = c_op_slt;
`else
      c_op_slt: alu_decode = c_op_add;
`endif
      default:  alu_decode = c_op_add;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
// Module : alu_slice
// Brief  : SLICE-bit combinational ALU datapath with carry in/out and the
//          carry into the slice MSB (for overflow detection).
// Rev    : 1.0  initial release
// ============================================================================
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             binvert,
  input  logic             carry_in,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] result,
  output logic             carry_out,
  output logic             carry_msb
);

  logic [SLICE-1:0] w_b_eff;
  logic [SLICE:0]   w_sum;

  assign w_b_eff   = binvert ? ~b : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, carry_in};
  assign carry_out = w_sum[SLICE];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
  assign carry_msb = w_sum[SLICE-1] ^ a[SLICE-1] ^ w_b_eff[SLICE-1];

  always_comb begin
    case (op)
      c_op_and: result = a & b;
      c_op_or:  result = a | b;
      c_op_nor: result = ~(a | b);
      default:  result = w_sum[SLICE-1:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sliced.sv
`default_nettype none
// ============================================================================
// Module : alu_sliced
// Brief  : Bit-serial-by-slice ALU: WIDTH/SLICE cycles per operation with a
//          valid/ready handshake. Macro ALU_SLT_EN enables op 111 (SLT).
// Rev    : 1.0  initial release
// ============================================================================
module alu_sliced
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid, r_carry_out, r_overflow, r_zero;

  int               w_base;
  logic [SLICE-1:0] w_sl_res;
  logic             w_cout, w_cmsb, w_last, w_arith;
  logic [WIDTH-1:0] w_res_full;

  assign w_base  = int'(r_cnt) * SLICE;
  assign w_last  = (r_cnt == CW'(NSL - 1));
  assign w_arith = !((r_op == c_op_and) || (r_op == c_op_or) || (r_op == c_op_nor));

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a         (r_a[w_base +: SLICE]),
    .b         (r_b[w_base +: SLICE]),
    .binvert   (r_op[2]),
    .carry_in  (r_carry),
    .op        (r_op),
    .result    (w_sl_res),
    .carry_out (w_cout),
    .carry_msb (w_cmsb)
  );

  always_comb begin
    w_res_full = r_res;
    w_res_full[w_base +: SLICE] = w_sl_res;
`ifdef ALU_SLT_EN
    // Signed less-than: sign of (a-b) corrected by overflow, on the MSB slice.
    if (w_last && (r_op == c_op_slt))
      w_res_full = {{(WIDTH-1){1'b0}}, w_sl_res[SLICE-1] ^ w_cmsb ^ w_cout};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= c_op_add;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= alu_decode(op);
            r_carry <= alu_decode(op) == c_op_sub || alu_decode(op) == c_op_slt;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_res   <= w_res_full;
          r_carry <= w_cout;
          if (w_last) begin
            r_cnt       <= '0;
            r_carry_out <= w_arith & w_cout;
            r_overflow  <= w_arith & (w_cmsb ^ w_cout);
            r_zero      <= (w_res_full == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_sliced.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_sliced
// Brief  : Self-checking bench for alu_sliced (WIDTH=32, SLICE=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_sliced;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry_out, overflow, zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_sliced #(.WIDTH(32), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built from two's-complement arithmetic on 33-bit values.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic c, output logic v,
                                output logic z);
    logic [32:0] s;
    logic        is_sub;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b100: r = ~(x | y);
      default: begin
        is_sub = (o == 3'b110);
`ifdef ALU_SLT_EN
        if (o == 3'b111) is_sub = 1'b1;
`endif
        if (is_sub) begin
          s = {1'b0, x} + {1'b0, ~y} + 33'd1;
          v = (x[31] != y[31]) && (s[31] != x[31]);
        end else begin
          s = {1'b0, x} + {1'b0, y};
          v = (x[31] == y[31]) && (s[31] != x[31]);
        end
        r = s[31:0];
        c = s[32];
`ifdef ALU_SLT_EN
        if (o == 3'b111) r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`endif
      end
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold);
    logic [31:0] er;
    logic        ec, ev, ez;
    int          n;
    model(o, x, y, er, ec, ev, ez);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    a = x; b = y; op = o; in_valid = 1'b1;
    @(negedge clk);
    // Scramble inputs to confirm the operands were captured, not resampled.
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    check("in_ready_busy", {31'b0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, 32'd8);
    check("result", result, er);
    check("carry_out", {31'b0, carry_out}, {31'b0, ec});
    check("overflow", {31'b0, overflow}, {31'b0, ev});
    check("zero", {31'b0, zero}, {31'b0, ez});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_result", result, er);
      check("hold_flags", {29'b0, carry_out, overflow, zero}, {29'b0, ec, ev, ez});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", {31'b0, out_valid}, 32'd0);
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'b0, carry_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed boundary cases
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(3'b110, 32'h8000_0000, 32'h0000_0001, 1);
    run_op(3'b111, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    run_op(3'b111, 32'h0000_0003, 32'hFFFF_FFFE, 0);
    run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5);
    run_op(3'b011, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(3'b101, 32'h1234_5678, 32'h1111_1111, 0);
    run_op(3'b000, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 0);
    run_op(3'b110, 32'h0000_0005, 32'h0000_0005, 0);

    // Randomized ops against the model
    for (int k = 0; k < 30; k++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 3)));

    // Reset during the 4th BUSY cycle abandons the operation
    a = 32'h0000_0010; b = 32'h0000_0020; op = 3'b010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_output", seen, 32'd0);
    end
    check("abort_idle_after", {31'b0, in_ready}, 32'd1);

    // Normal operation resumes after the abort
    run_op(3'b010, 32'h0000_0010, 32'h0000_0020, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sliced.md
ALU_SLICED -- requirements
Module: alu_sliced

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4, bits processed per cycle; SHALL be ≥1 and ≤WIDTH.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 carry_out, overflow, zero  output  1 each  status flags.

Function
REQ-013 FSM states IDLE, BUSY, DONE; IDLE->BUSY on in_valid&&in_ready; BUSY->DONE after NSL=WIDTH/SLICE slice cycles; DONE->IDLE on out_ready.
REQ-014 in_ready SHALL be 1 only in IDLE; a, b, op SHALL be captured into registers on acceptance and not resampled afterwards.
REQ-015 Slice k (k=0..NSL-1) SHALL be computed in the k-th BUSY cycle, LSB slice first, carry held in a register between slices.
REQ-016 Binvert = op[2]; initial carry-in = op[2] (SUB/SLT = a + ~b + 1); NOR = ~(a|b).
REQ-017 AND/OR/NOR operate on unmodified b; ADD/SUB/SLT use the inverted-or-not b path.
REQ-018 Latency: acceptance at edge E -> out_valid high after edge E+NSL; result, flags stable while out_valid=1.
REQ-019 carry_out = carry out of MSB for ADD/SUB/SLT, 0 for logic ops.
REQ-020 overflow = carry-into-MSB XOR carry-out-of-MSB for ADD/SUB/SLT, 0 for logic ops.
REQ-021 SLT result = {WIDTH-1 zeros, sign(a-b) XOR overflow}, produced on the BUSY->DONE transition.
REQ-022 zero = (result == 0), for every op.
REQ-023 Undefined op codes (011, 101) SHALL produce the ADD result and flags.
REQ-024 Back-to-back: in DONE with out_ready=1, in_ready SHALL go high the next cycle (no same-cycle accept); in_valid during BUSY/DONE SHALL be ignored.
REQ-025 out_valid held with out_ready=0 SHALL remain held indefinitely, outputs unchanged.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, out_valid=0, result=0, carry_out=0, overflow=0, zero=0, internal carry=0, slice counter=0.
REQ-027 Reset in BUSY or DONE SHALL abandon the operation; no out_valid for it afterwards.
REQ-028 in_ready SHALL be 1 the first cycle after reset deasserts.

Configuration
REQ-029 Macro ALU_SLT_EN: defined -> op 111 performs SLT per REQ-021.
REQ-030 Without ALU_SLT_EN -> op 111 treated as undefined per REQ-023 (ADD result), no SLT logic synthesised.

Structure
REQ-031 Package alu_pkg SHALL hold op-code constants, FSM state enumeration typedef.
REQ-032 Sub-module alu_slice SHALL be the SLICE-bit combinational datapath (a, b slice, binvert, carry-in, op -> result slice, carry-out, carry-into-MSB); alu_sliced instantiates one.

Verification (WIDTH=32, SLICE=4, NSL=8)
REQ-033 ADD 0xFFFFFFFF+0x00000001 -> result 0, carry_out 1, overflow 0, zero 1, out_valid 8 cycles after accept.
REQ-034 SUB 0x80000000-0x00000001 -> result 0x7FFFFFFF, overflow 1, carry_out 1.
REQ-035 SLT a=0xFFFFFFFE(-2), b=0x00000003 -> result 1; with ALU_SLT_EN undefined -> result 0x00000001 (ADD), zero 0.
REQ-036 AND/OR/NOR a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x000F000F, carry_out 0, overflow 0.
REQ-037 out_ready=0 for 5 cycles after out_valid -> result/flags unchanged, in_ready 0; new in_valid pulses ignored.
REQ-038 rst_n low in 4th BUSY cycle -> next cycle IDLE, out_valid 0, in_ready 1, no result emitted.
